// File: rtl/write_back_stage.sv
// Write-back stage: captures a completed instruction, performs the data-memory
// read for loads (with byte/half/word extraction), then drives one register-file write.
module write_back_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exeValid,
  output logic          exeReady,
  input  logic [DW-1:0] aluRes,
  input  logic          memRead,
  input  logic [1:0]    memSize,
  input  logic          memSigned,
  input  logic          regWrite,
  input  logic          wriReg,
  input  logic [AW-1:0] irOutRt,
  input  logic [AW-1:0] irOutRd,
  output logic          memReq,
  output logic [DW-1:0] memAddr,
  input  logic          memAck,
  input  logic [DW-1:0] memRdata,
  output logic          rfWrEn,
  output logic [AW-1:0] rfWrAddr,
  output logic [DW-1:0] muxForOut,
  output logic          wbDone,
  output logic          errMisalign
);

  typedef enum logic [1:0] {IDLE, MEMRD, WRITE} state_t;

  state_t        state_reg;
  logic [DW-1:0] alu_out_reg;
  logic [DW-1:0] result_reg;
  logic [AW-1:0] dest_reg;
  logic [1:0]    size_reg;
  logic          signed_reg;
  logic          reg_write_reg;
  logic          misalign_reg;

  logic          accept;
  logic          misalign_in;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_data;

  assign accept = exeValid && exeReady;

  // Only the incoming load's size/address matter; byte loads can never be misaligned.
  always_comb begin
    misalign_in = 1'b0;
    if (memRead) begin
      if (memSize == 2'b01)
        misalign_in = aluRes[0];
      else if (memSize != 2'b10)
        misalign_in = (aluRes[1:0] != 2'b00);
    end
  end

  always_comb begin
    byte_sel  = memRdata[{alu_out_reg[1:0], 3'b000} +: 8];
    half_sel  = memRdata[{alu_out_reg[1], 4'b0000} +: 16];
    load_data = memRdata;
    case (size_reg)
      2'b10:   load_data = {{(DW-8){signed_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{(DW-16){signed_reg & half_sel[15]}}, half_sel};
      default: load_data = memRdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      alu_out_reg   <= '0;
      result_reg    <= '0;
      dest_reg      <= '0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      reg_write_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_out_reg   <= aluRes;
            size_reg      <= memSize;
            signed_reg    <= memSigned;
            reg_write_reg <= regWrite;
            misalign_reg  <= misalign_in;
            dest_reg      <= wriReg ? irOutRd : irOutRt;
            if (!memRead)
              result_reg <= aluRes;
            state_reg <= (memRead && !misalign_in) ? MEMRD : WRITE;
          end
        end
        MEMRD: begin
          if (memAck) begin
            result_reg <= load_data;
            state_reg  <= WRITE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state; rst forces them quiet in the reset cycle.
  assign exeReady    = (state_reg == IDLE) && !rst;
  assign memReq      = (state_reg == MEMRD) && !rst;
  assign memAddr     = memReq ? {alu_out_reg[DW-1:2], 2'b00} : '0;
  assign wbDone      = (state_reg == WRITE) && !rst;
  assign errMisalign = wbDone && misalign_reg;
  assign rfWrEn      = wbDone && reg_write_reg && (dest_reg != '0) && !misalign_reg;
  assign rfWrAddr    = rst ? '0 : dest_reg;
  assign muxForOut   = rst ? '0 : result_reg;

endmodule
